// File: rtl/sha256_mem_responder_if.sv
// rtl/sha256_mem_responder_if.sv - signal bundle between the SHA-256 memory responder and its host/engine
//
// Purpose: groups the host preload port, the job handshake, the engine control
// and memory port, and the hash output stream into one interface.
//
// Modports:
//   slave  - the responder: samples host/job/engine requests, drives responses
//   master - the host plus engine side of the same signals
interface sha256_mem_responder_if;
  // Host preload
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  // Job handshake
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_msg_addr;
  logic [15:0] job_out_addr;
  logic        job_error;
  // Engine control
  logic        sha_start;
  logic [15:0] sha_message_addr;
  logic [15:0] sha_output_addr;
  logic        sha_done;
  // Engine memory port
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  // Hash output stream
  logic        hash_valid;
  logic        hash_ready;
  logic [31:0] hash_data;
  logic [2:0]  hash_index;
  logic        hash_last;

  modport slave (
    input  host_we, host_addr, host_wdata,
    input  job_valid, job_msg_addr, job_out_addr,
    output job_ready, job_error,
    output sha_start, sha_message_addr, sha_output_addr,
    input  sha_done,
    input  mem_we, mem_addr, mem_write_data,
    output mem_read_data,
    output hash_valid, hash_data, hash_index, hash_last,
    input  hash_ready
  );

  modport master (
    output host_we, host_addr, host_wdata,
    output job_valid, job_msg_addr, job_out_addr,
    input  job_ready, job_error,
    input  sha_start, sha_message_addr, sha_output_addr,
    output sha_done,
    output mem_we, mem_addr, mem_write_data,
    input  mem_read_data,
    input  hash_valid, hash_data, hash_index, hash_last,
    output hash_ready
  );
endinterface

// File: rtl/sha256_mem_responder.sv
// rtl/sha256_mem_responder.sv - memory responder and job sequencer for the simplified SHA-256 engine
//
// Purpose: owns the engine's word-addressed message/hash memory, runs one hash
// job at a time (start pulse, busy/done tracking, busy timeout) and streams the
// eight resulting hash words back to the host.
//
// Ports:
//   clk     - single clock, also the engine's memory clock
//   reset_n - asynchronous active-low reset
//   bus     - sha256_mem_responder_if.slave: host preload, job handshake,
//             engine control, engine memory port and hash output stream
module sha256_mem_responder #(
  parameter int DEPTH        = 1024,
  parameter int BUSY_TIMEOUT = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  sha256_mem_responder_if.slave bus
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RD_ISSUE,
    S_RD_HOLD
  } state_t;

  state_t        r_state;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_mem_read_data;
  logic [15:0]   r_msg_addr;
  logic [15:0]   r_out_addr;
  logic          r_sha_start;
  logic          r_job_error;
  logic [CW-1:0] r_busy_cnt;
  logic [2:0]    r_idx;
  logic          r_hash_valid;
  logic [31:0]   r_hash_data;
  logic [2:0]    r_hash_index;
  logic          r_hash_last;

  logic          w_job_ready;
  logic          w_host_wr;
  logic          w_eng_wr;
  logic          w_wr_en;
  logic [15:0]   w_wr_addr;
  logic [31:0]   w_wr_data;
  logic [15:0]   w_rd_addr;
  logic [31:0]   w_rd_data;

  function automatic logic in_range(input logic [15:0] addr);
    return {16'd0, addr} < DEPTH_W;
  endfunction

  // job_ready has to track sha_done in the same cycle, so it is the one
  // combinational output; it is forced low while reset is asserted.
  assign w_job_ready = reset_n && (r_state == S_IDLE) && bus.sha_done;

  // Single write port: host writes only in IDLE, engine writes only while the
  // engine is actually running (it holds mem_we high when idle). The two
  // windows never overlap, so a simple mux picks the source.
  assign w_host_wr = (r_state == S_IDLE) && bus.host_we;
  assign w_eng_wr  = ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE)) && bus.mem_we;
  assign w_wr_addr = w_host_wr ? bus.host_addr  : bus.mem_addr;
  assign w_wr_data = w_host_wr ? bus.host_wdata : bus.mem_write_data;
  assign w_wr_en   = reset_n && (w_host_wr || w_eng_wr) && in_range(w_wr_addr);

  // Second read port for the hash readout; the 16-bit add wraps naturally.
  assign w_rd_addr = r_out_addr + {13'd0, r_idx};
  assign w_rd_data = in_range(w_rd_addr) ? r_mem[w_rd_addr[AW-1:0]] : 32'd0;

  // Memory array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr[AW-1:0]] <= w_wr_data;
    end
  end

  // Engine read port: registered every cycle in every state. A same-cycle
  // write to the same address is seen on the following read only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_read_data <= 32'd0;
    end else begin
      r_mem_read_data <= in_range(bus.mem_addr) ? r_mem[bus.mem_addr[AW-1:0]] : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_msg_addr   <= 16'd0;
      r_out_addr   <= 16'd0;
      r_sha_start  <= 1'b0;
      r_job_error  <= 1'b0;
      r_busy_cnt   <= '0;
      r_idx        <= 3'd0;
      r_hash_valid <= 1'b0;
      r_hash_data  <= 32'd0;
      r_hash_index <= 3'd0;
      r_hash_last  <= 1'b0;
    end else begin
      r_sha_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.job_valid && w_job_ready) begin
            r_msg_addr  <= bus.job_msg_addr;
            r_out_addr  <= bus.job_out_addr;
            r_job_error <= 1'b0;
            r_sha_start <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_busy_cnt <= CW'(BUSY_TIMEOUT);
          r_state    <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // The engine must acknowledge start by dropping done; if it never
          // does, give up after BUSY_TIMEOUT samples and flag the job.
          if (!bus.sha_done) begin
            r_state <= S_WAIT_DONE;
          end else if (r_busy_cnt <= CW'(1)) begin
            r_job_error <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_busy_cnt <= r_busy_cnt - CW'(1);
          end
        end
        S_WAIT_DONE: begin
          if (bus.sha_done) begin
            r_idx   <= 3'd0;
            r_state <= S_RD_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          // Word is captured here but presented one cycle later, so the
          // stream fields are already settled when valid rises.
          r_hash_data  <= w_rd_data;
          r_hash_index <= r_idx;
          r_hash_last  <= (r_idx == 3'd7);
          r_state      <= S_RD_HOLD;
        end
        S_RD_HOLD: begin
          if (!r_hash_valid) begin
            r_hash_valid <= 1'b1;
          end else if (bus.hash_ready) begin
            r_hash_valid <= 1'b0;
            if (r_idx == 3'd7) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= S_RD_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.job_ready        = w_job_ready;
  assign bus.job_error        = r_job_error;
  assign bus.sha_start        = r_sha_start;
  assign bus.sha_message_addr = r_msg_addr;
  assign bus.sha_output_addr  = r_out_addr;
  assign bus.mem_read_data    = r_mem_read_data;
  assign bus.hash_valid       = r_hash_valid;
  assign bus.hash_data        = r_hash_data;
  assign bus.hash_index       = r_hash_index;
  assign bus.hash_last        = r_hash_last;

endmodule

// File: tb/tb_sha256_mem_responder.sv
// tb/tb_sha256_mem_responder.sv - scoreboard testbench for sha256_mem_responder
module tb_sha256_mem_responder;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sha256_mem_responder_if bus ();

  sha256_mem_responder #(
    .DEPTH       (1024),
    .BUSY_TIMEOUT(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int stall_n = 0;
  int stall_cnt = 0;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [31:0] exp;
  } rd_t;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        last;
  } hw_t;

  rd_t rq[$];
  hw_t hq[$];
  bit  prev_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host ready driver: holds ready low for stall_n cycles of each valid word.
  always @(posedge clk) begin
    #1;
    if (!bus.hash_valid) begin
      stall_cnt      = 0;
      bus.hash_ready = (stall_n == 0);
    end else if (stall_cnt < stall_n) begin
      stall_cnt++;
      bus.hash_ready = 1'b0;
    end else begin
      bus.hash_ready = 1'b1;
    end
  end

  // Engine read monitor: data for an address presented in cycle c is checked in cycle c+1.
  always @(negedge clk) begin
    while (rq.size() > 0 && rq[0].due <= cyc) begin
      if (rq[0].due == cyc)
        chk($sformatf("mem_read_data@%04h", rq[0].addr), bus.mem_read_data, rq[0].exp);
      void'(rq.pop_front());
    end
  end

  // Hash stream monitor: compares every presented word with the queue head,
  // pops on handshake, and requires valid to stay up through a stall.
  always @(negedge clk) begin
    if (reset_n && prev_stall)
      chk("hash_valid_hold", 32'(bus.hash_valid), 32'd1);
    if (reset_n && bus.hash_valid) begin
      if (hq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hash_unexpected: got data 0x%08h index %0d, expected no word", bus.hash_data, bus.hash_index);
      end else begin
        chk($sformatf("hash_data[%0d]", hq[0].idx), bus.hash_data, hq[0].data);
        chk($sformatf("hash_index[%0d]", hq[0].idx), 32'(bus.hash_index), 32'(hq[0].idx));
        chk($sformatf("hash_last[%0d]", hq[0].idx), 32'(bus.hash_last), 32'(hq[0].last));
        if (bus.hash_ready) void'(hq.pop_front());
      end
    end
    prev_stall = reset_n && bus.hash_valid && !bus.hash_ready;
  end

  task automatic host_wr(input logic [15:0] addr, input logic [31:0] data);
    bus.host_we    = 1'b1;
    bus.host_addr  = addr;
    bus.host_wdata = data;
    tick();
    bus.host_we = 1'b0;
  endtask

  task automatic eng_read(input logic [15:0] addr, input logic [31:0] exp);
    bus.mem_we   = 1'b0;
    bus.mem_addr = addr;
    rq.push_back('{cyc + 1, addr, exp});
    tick();
  endtask

  // Write and read share mem_addr, so the read in the same cycle returns old data.
  task automatic eng_write(input logic [15:0] addr, input logic [31:0] data, input logic [31:0] old);
    bus.mem_we         = 1'b1;
    bus.mem_addr       = addr;
    bus.mem_write_data = data;
    rq.push_back('{cyc + 1, addr, old});
    tick();
  endtask

  task automatic run_job(input logic [15:0] out, input bit do_wr,
                         input logic [7:0][31:0] wr_data, input logic [7:0][31:0] wr_old,
                         input logic [7:0][31:0] exp_hash, input int stall);
    int n;
    stall_n = stall;
    bus.job_msg_addr = 16'h0000;
    bus.job_out_addr = out;
    bus.job_valid    = 1'b1;
    chk("job_ready_idle", 32'(bus.job_ready), 32'd1);
    tick();
    bus.job_valid = 1'b0;
    chk("sha_start_pulse", 32'(bus.sha_start), 32'd1);
    chk("sha_message_addr", 32'(bus.sha_message_addr), 32'h0);
    chk("sha_output_addr", 32'(bus.sha_output_addr), 32'(out));
    chk("job_error_clear", 32'(bus.job_error), 32'd0);
    bus.sha_done = 1'b0;
    tick();
    chk("sha_start_one_cycle", 32'(bus.sha_start), 32'd0);
    for (int i = 0; i < 20; i++) eng_read(16'(i), 32'h1000 + 32'(i));
    // Host write while the job runs must be ignored.
    host_wr(16'd5, 32'h0BAD);
    eng_read(16'd5, 32'h1005);
    if (do_wr)
      for (int k = 0; k < 8; k++) eng_write(out + 16'(k), wr_data[k], wr_old[k]);
    for (int k = 0; k < 8; k++) hq.push_back('{exp_hash[k], 3'(k), (k == 7)});
    bus.sha_done = 1'b1;
    tick();
    // Engine idles with we held high; these writes must be dropped.
    bus.mem_we         = 1'b1;
    bus.mem_addr       = 16'h0000;
    bus.mem_write_data = 32'hDEAD;
    bus.job_valid      = 1'b1;
    chk("job_ready_busy_d0", 32'(bus.job_ready), 32'd0);
    chk("hash_valid_d0", 32'(bus.hash_valid), 32'd0);
    tick();
    chk("job_ready_busy_d1", 32'(bus.job_ready), 32'd0);
    chk("hash_valid_d1", 32'(bus.hash_valid), 32'd0);
    bus.job_valid = 1'b0;
    tick();
    chk("hash_valid_d2", 32'(bus.hash_valid), 32'd1);
    n = 0;
    while (hq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("hash_drain", 32'(hq.size()), 32'd0);
    chk("job_ready_after", 32'(bus.job_ready), 32'd1);
    chk("no_queued_start", 32'(bus.sha_start), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0][31:0] wa, wb, old_pre, zeros, wrap_exp;
    int n;

    for (int k = 0; k < 8; k++) begin
      wa[k]       = 32'hA0 + 32'(k);
      wb[k]       = 32'hB0 + 32'(k);
      old_pre[k]  = 32'h2000 + 32'(k);
      zeros[k]    = 32'h0;
      wrap_exp[k] = (k < 4) ? 32'h0 : 32'h1000 + 32'(k - 4);
    end

    // Reset with random inputs
    reset_n = 1'b0;
    repeat (6) begin
      bus.host_we        = 1'($urandom);
      bus.host_addr      = 16'($urandom);
      bus.host_wdata     = $urandom;
      bus.job_valid      = 1'($urandom);
      bus.job_msg_addr   = 16'($urandom);
      bus.job_out_addr   = 16'($urandom);
      bus.sha_done       = 1'($urandom);
      bus.mem_we         = 1'($urandom);
      bus.mem_addr       = 16'($urandom);
      bus.mem_write_data = $urandom;
      tick();
    end
    bus.sha_done = 1'b1;
    bus.job_valid = 1'b1;
    #1;
    chk("rst_job_ready", 32'(bus.job_ready), 32'd0);
    chk("rst_job_error", 32'(bus.job_error), 32'd0);
    chk("rst_sha_start", 32'(bus.sha_start), 32'd0);
    chk("rst_sha_message_addr", 32'(bus.sha_message_addr), 32'd0);
    chk("rst_sha_output_addr", 32'(bus.sha_output_addr), 32'd0);
    chk("rst_mem_read_data", bus.mem_read_data, 32'd0);
    chk("rst_hash_valid", 32'(bus.hash_valid), 32'd0);
    chk("rst_hash_data", bus.hash_data, 32'd0);
    chk("rst_hash_index", 32'(bus.hash_index), 32'd0);
    chk("rst_hash_last", 32'(bus.hash_last), 32'd0);
    bus.host_we   = 1'b0;
    bus.job_valid = 1'b0;
    bus.mem_we    = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    chk("rst_release_job_ready", 32'(bus.job_ready), 32'd1);
    tick();

    // Preload and IDLE write gating
    for (int i = 0; i < 20; i++) host_wr(16'(i), 32'h1000 + 32'(i));
    for (int k = 0; k < 8; k++) host_wr(16'h0100 + 16'(k), 32'h2000 + 32'(k));
    host_wr(16'h0400, 32'h5555);
    repeat (3) eng_write(16'h0000, 32'hDEAD, 32'h1000);
    eng_read(16'h0000, 32'h1000);
    eng_read(16'd19, 32'h1013);
    eng_read(16'h0400, 32'h0);
    eng_read(16'h0100, 32'h2000);

    // Full job, no stall
    run_job(16'h0100, 1'b1, wa, old_pre, wa, 0);
    // Same job with backpressure, new hash words over the previous ones
    run_job(16'h0100, 1'b1, wb, wa, wb, 5);

    // Busy timeout
    bus.mem_we       = 1'b0;
    bus.job_msg_addr = 16'h0123;
    bus.job_out_addr = 16'h0200;
    bus.job_valid    = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    chk("to_sha_start", 32'(bus.sha_start), 32'd1);
    chk("to_sha_message_addr", 32'(bus.sha_message_addr), 32'h0123);
    repeat (4) tick();
    chk("to_error_early", 32'(bus.job_error), 32'd0);
    chk("to_job_ready_busy", 32'(bus.job_ready), 32'd0);
    tick();
    chk("to_error_set", 32'(bus.job_error), 32'd1);
    chk("to_back_in_idle", 32'(bus.job_ready), 32'd1);
    tick();
    tick();
    chk("to_error_sticky", 32'(bus.job_error), 32'd1);

    // Output address wraps past 0xFFFF
    run_job(16'hFFFC, 1'b0, zeros, zeros, wrap_exp, 0);
    // Output address beyond the memory: writes dropped, reads zero
    run_job(16'h0400, 1'b1, wa, zeros, zeros, 2);

    // Reset during RD_HOLD
    bus.mem_we       = 1'b0;
    stall_n          = 1000;
    bus.job_msg_addr = 16'h0042;
    bus.job_out_addr = 16'h0100;
    bus.job_valid    = 1'b1;
    tick();
    bus.job_valid = 1'b0;
    bus.sha_done  = 1'b0;
    tick();
    tick();
    hq.push_back('{32'hB0, 3'd0, 1'b0});
    bus.sha_done = 1'b1;
    n = 0;
    while (!bus.hash_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rst_hold_valid_seen", 32'(bus.hash_valid), 32'd1);
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_hold_hash_valid", 32'(bus.hash_valid), 32'd0);
    chk("rst_hold_hash_data", bus.hash_data, 32'd0);
    chk("rst_hold_sha_output_addr", 32'(bus.sha_output_addr), 32'd0);
    chk("rst_hold_sha_message_addr", 32'(bus.sha_message_addr), 32'd0);
    chk("rst_hold_mem_read_data", bus.mem_read_data, 32'd0);
    chk("rst_hold_job_ready", 32'(bus.job_ready), 32'd0);
    hq.delete();
    tick();
    stall_n = 0;
    reset_n = 1'b1;
    #1;
    chk("rst_hold_release_ready", 32'(bus.job_ready), 32'd1);
    tick();
    eng_read(16'h0100, 32'hB0);
    eng_read(16'h0000, 32'h1000);
    tick();
    tick();
    chk("rd_queue_empty", 32'(rq.size()), 32'd0);
    chk("hash_queue_empty", 32'(hq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_mem_responder.md
# sha256_mem_responder

Memory-side responder and job sequencer for the `simplified_sha256` engine. It owns the word-addressed message/hash memory and answers the engine's `mem_*` port with one-cycle registered reads and gated writes. It also accepts host jobs, pulses the engine's `start`, tracks `done`, and streams the 8 resulting hash words to the host over a valid/ready interface. It sits between the host/testbench and the engine, on the far end of the engine's memory interface.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; valid addresses are 0..DEPTH-1.
- `BUSY_TIMEOUT`, 4: cycles allowed for `sha_done` to fall after `sha_start`.

Ports:
- `clk` in 1: single clock; the engine's `mem_clk` is `clk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `host_we` in 1: host preload write strobe.
- `host_addr` in 16: host preload word address.
- `host_wdata` in 32: host preload data.
- `job_valid` in 1: job request.
- `job_ready` out 1: job accepted when both `job_valid` and `job_ready` are high.
- `job_msg_addr` in 16: message base word address.
- `job_out_addr` in 16: hash output base word address.
- `job_error` out 1: sticky timeout flag; cleared on the next job acceptance.
- `sha_start` out 1: engine start pulse.
- `sha_message_addr` out 16: registered copy of `job_msg_addr`.
- `sha_output_addr` out 16: registered copy of `job_out_addr`.
- `sha_done` in 1: engine done; high while the engine is idle.
- `mem_we` in 1: engine write enable.
- `mem_addr` in 16: engine word address.
- `mem_write_data` in 32: engine write data.
- `mem_read_data` out 32: registered read data returned to the engine.
- `hash_valid` out 1: hash word available.
- `hash_ready` in 1: host accepts the hash word.
- `hash_data` out 32: hash word.
- `hash_index` out 3: index of the word, 0 = h0 … 7 = h7.
- `hash_last` out 1: high with index 7.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, RD_ISSUE, RD_HOLD.
- IDLE:
  - `job_ready = sha_done`.
  - `host_we` writes `mem[host_addr]`; host writes are ignored in every other state.
  - On job handshake: latch both addresses, clear `job_error`, go to START.
- START:
  - `sha_start = 1` for exactly one cycle.
  - Go to WAIT_BUSY and load the timeout counter.
- WAIT_BUSY:
  - When `sha_done == 0`, go to WAIT_DONE.
  - If `sha_done` stays 1 for `BUSY_TIMEOUT` cycles, set `job_error` and return to IDLE.
- WAIT_DONE:
  - When `sha_done == 1`, go to RD_ISSUE with `idx = 0`.
- Engine memory port, serviced in all states:
  - Every cycle, `mem_read_data <= mem[mem_addr]`.
  - An engine write (`mem_we`) is honoured only in WAIT_BUSY and WAIT_DONE. In every other state it is dropped, because the engine holds `we` asserted while idle.
- Host-side readout uses a second read port:
  - RD_ISSUE reads `mem[sha_output_addr + idx]`, with the address taken modulo 2^16.
  - RD_HOLD holds `hash_valid = 1` until `hash_ready` is high.
  - On a handshake with `idx == 7`, go to IDLE; otherwise increment `idx` and go to RD_ISSUE.
- Address range: any access at or above `DEPTH` reads 0 and drops the write.
- Write/read collision: a read of the same address in the same cycle returns the old data.
- Memory contents are not reset.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0, including `mem_read_data`, `hash_*`, `sha_start`, `job_error` and the `sha_*_addr` outputs.
  - `job_ready` follows `sha_done` once `reset_n` is released.
- Engine read latency is 1 cycle: the address presented at edge N produces data valid after edge N+1.
- Job-to-start latency: with the handshake sampled at edge E, `sha_start` is high between E and E+1.
- Done-to-data latency: with `sha_done == 1` sampled in WAIT_DONE at edge D, `hash_valid` rises after D+2.
- Readout throughput is at most 1 word per 2 cycles.
- While `hash_valid == 1` and `hash_ready == 0`:
  - `hash_data`, `hash_index` and `hash_last` stay stable.
  - `hash_valid` stays high.
- `job_valid` outside IDLE is not accepted and is not queued.
- Reset asserted mid-job, in any state, aborts immediately to IDLE. A partial readout is discarded.

## Test plan
- Reset: assert `reset_n = 0` with random inputs → all outputs 0; after release with `sha_done = 1`, `job_ready = 1`.
- Full job, bench acting as the engine:
  - Stimulus: preload words 0x1000+i at addresses 0..19, then submit a job with msg 0x0000 and out 0x0100. After `sha_start`, drop `sha_done`, read addresses 0..19, write 0xA0..0xA7 to 0x0100..0x0107, then raise `sha_done`.
  - Required: each read returns 0x1000+i one cycle after its address; the stream delivers 0xA0..0xA7 with index 0..7 and `hash_last` only on 0xA7.
- Backpressure: same job, with `hash_ready` low for 5 cycles per word → no word is lost or duplicated, and outputs stay stable while stalled.
- Write gating:
  - Engine `mem_we = 1` at address 0 with data 0xDEAD while in IDLE → `mem[0]` is unchanged.
  - Host write during WAIT_DONE → ignored.
  - `job_valid` during a job → `job_ready = 0`.
- Timeout: hold `sha_done = 1` after `sha_start` → `job_error = 1` after 4 cycles, FSM back in IDLE; the next accepted job clears `job_error`.
- Boundaries:
  - Out address 0xFFFC → readout wraps to 0x0000..0x0003.
  - Out address at or above `DEPTH` → reads return 0.
  - Reset during RD_HOLD → `hash_valid = 0` immediately.
